mcpu_prog_loader: RTL and testbench

MCPU_PROG_LOADER -- requirements
Module: mcpu_prog_loader

---
 rtl/mcpu_pkg.sv | 31 +++
 rtl/mcpu_prog_loader.sv | 139 +++++++++++++
 tb/tb_mcpu_prog_loader.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_pkg.sv
// Shared MCPU definitions: loader state encoding, default geometry, byte order and opcodes.
package mcpu_pkg;

    localparam int unsigned DEF_WORD_SIZE  = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned BYTE_W         = 8;

    // Instruction words arrive high byte first.
    localparam bit MSB_BYTE_FIRST = 1'b1;

    typedef enum logic [2:0] {
        LD_CLEAR = 3'd0,
        LD_LEN   = 3'd1,
        LD_HI    = 3'd2,
        LD_LO    = 3'd3,
        LD_DONE  = 3'd4
    } loader_state_e;

    // MCPU opcode field values (upper nibble of an instruction word).
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/mcpu_prog_loader.sv
// Program loader: clears the MCPU program RAM, then streams a length-prefixed
// image of big-endian words into it while holding the CPU in reset.
module mcpu_prog_loader
    import mcpu_pkg::*;
#(
    parameter int unsigned WORD_SIZE  = DEF_WORD_SIZE,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    output logic                  cpu_reset,
    output logic                  done
);

    // One extra counter bit so a length of 2**ADDR_WIDTH terminates without wrapping.
    localparam int unsigned            CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]       FULL_LEN = CNT_W'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0]  CLR_LAST = '1;

    loader_state_e           state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_addr, clr_addr_nxt;
    logic [CNT_W-1:0]        count, count_nxt;
    logic [CNT_W-1:0]        len, len_nxt;
    logic [BYTE_W-1:0]       hi_byte, hi_byte_nxt;
    logic [CNT_W-1:0]        count_inc;
    logic [2*BYTE_W-1:0]     word;
    logic                    take;

    logic                    mem_we_nxt;
    logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
    logic [WORD_SIZE-1:0]    mem_wdata_nxt;
    logic                    in_ready_nxt;
    logic                    cpu_reset_nxt;
    logic                    done_nxt;

    // State, bookkeeping and all outputs are registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LD_CLEAR;
            clr_addr  <= '0;
            count     <= '0;
            len       <= '0;
            hi_byte   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            in_ready  <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_addr  <= clr_addr_nxt;
            count     <= count_nxt;
            len       <= len_nxt;
            hi_byte   <= hi_byte_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            in_ready  <= in_ready_nxt;
            cpu_reset <= cpu_reset_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state and next-output logic; a byte moves only when in_valid meets the registered in_ready.
    always_comb begin
        state_nxt     = state;
        clr_addr_nxt  = clr_addr;
        count_nxt     = count;
        len_nxt       = len;
        hi_byte_nxt   = hi_byte;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        take          = in_valid && in_ready;
        count_inc     = count + CNT_W'(1);
        word          = MSB_BYTE_FIRST ? {hi_byte, in_data} : {in_data, hi_byte};

        case (state)
            LD_CLEAR: begin
                mem_we_nxt    = 1'b1;
                mem_addr_nxt  = clr_addr;
                mem_wdata_nxt = '0;
                clr_addr_nxt  = clr_addr + ADDR_WIDTH'(1);
                count_nxt     = '0;
                if (clr_addr == CLR_LAST) begin
                    state_nxt = LD_LEN;
                end
            end
            LD_LEN: begin
                if (take) begin
                    len_nxt   = (in_data == '0) ? FULL_LEN : CNT_W'(in_data);
                    state_nxt = LD_HI;
                end
            end
            LD_HI: begin
                if (take) begin
                    hi_byte_nxt = in_data;
                    state_nxt   = LD_LO;
                end
            end
            LD_LO: begin
                if (take) begin
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = count[ADDR_WIDTH-1:0];
                    mem_wdata_nxt = WORD_SIZE'(word);
                    count_nxt     = count_inc;
                    state_nxt     = (count_inc < len) ? LD_HI : LD_DONE;
                end
            end
            LD_DONE: begin
                // Reload: issue the first clear write right away so clearing still spans 256 cycles.
                if (start) begin
                    state_nxt     = LD_CLEAR;
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = '0;
                    mem_wdata_nxt = '0;
                    clr_addr_nxt  = ADDR_WIDTH'(1);
                    count_nxt     = '0;
                end
            end
            default: begin
                state_nxt = LD_CLEAR;
            end
        endcase

        in_ready_nxt  = (state_nxt == LD_LEN) || (state_nxt == LD_HI) || (state_nxt == LD_LO);
        cpu_reset_nxt = (state_nxt != LD_DONE);
        done_nxt      = (state_nxt == LD_DONE);
    end

endmodule

// File: tb/tb_mcpu_prog_loader.sv
// Bench for mcpu_prog_loader: byte-level reference model, per-cycle output compare,
// and literal checks on the captured RAM image.
module tb_mcpu_prog_loader;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        start    = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_reset;
    logic        done;

    int tests = 0;
    int fails = 0;

    mcpu_prog_loader #(.WORD_SIZE(16), .ADDR_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Collatz program image (20 words) and a stash for the gap-free image.
    logic [15:0] prog_a [20] = '{
        16'h1014, 16'h2100, 16'h1201, 16'h5312, 16'h7308, 16'h6110, 16'h8009, 16'h0000,
        16'h3111, 16'h3110, 16'h3112, 16'h1300, 16'h4331, 16'h7310, 16'h8003, 16'h2013,
        16'h1000, 16'h0000, 16'h0000, 16'hF000
    };
    logic [15:0] image_a [256];
    logic [15:0] prog_b  [5];

    // RAM written by the DUT, plus write counters.
    logic [15:0] ram [256];
    int wr_cnt = 0;
    int a0_cnt = 0;
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] = mem_wdata;
            wr_cnt++;
            if (mem_addr == 8'h00) a0_cnt++;
        end
    end

    // Reference model: counts clear writes left and bytes consumed since the clear.
    int m_clear_left = 256;
    int m_bytes = 0;
    int m_words = 0;
    int m_n = 0;
    int m_hi = 0;
    bit m_done = 0;
    bit m_we = 0;
    int m_addr = 0;
    int m_data = 0;
    bit m_ready = 0;
    int exp_img [256];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_clear_left = 256; m_bytes = 0; m_words = 0; m_done = 0;
            m_we = 0; m_addr = 0; m_data = 0; m_ready = 0;
        end else begin
            bit took;
            took = in_valid && m_ready;
            m_we = 0;
            if (m_done && start) begin
                m_done = 0; m_clear_left = 256; m_bytes = 0; m_words = 0;
            end
            if (m_clear_left > 0) begin
                m_we = 1; m_addr = 256 - m_clear_left; m_data = 0;
                exp_img[m_addr] = 0;
                m_clear_left--;
            end else if (took) begin
                if (m_bytes == 0) m_n = (in_data == 0) ? 256 : int'(in_data);
                else if (m_bytes % 2 == 1) m_hi = int'(in_data);
                else begin
                    m_we = 1; m_addr = m_words; m_data = m_hi * 256 + int'(in_data);
                    exp_img[m_addr] = m_data;
                    m_words++;
                    if (m_words == m_n) m_done = 1;
                end
                m_bytes++;
            end
            m_ready = (m_clear_left == 0) && !m_done;
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        logic [27:0] got, exp;
        got = {mem_we, mem_addr, mem_wdata, in_ready, cpu_reset, done};
        exp = {m_we, 8'(m_addr), 16'(m_data), m_ready, !m_done, m_done};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL outputs t=%0t got we=%b addr=%h data=%h rdy=%b crst=%b done=%b want we=%b addr=%h data=%h rdy=%b crst=%b done=%b",
                     $time, mem_we, mem_addr, mem_wdata, in_ready, cpu_reset, done,
                     m_we, 8'(m_addr), 16'(m_data), m_ready, !m_done, m_done);
        end
    end

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_cpu_reset", int'(cpu_reset), 1);
        check("rst_done", int'(done), 0);
        check("rst_mem_we", int'(mem_we), 0);
        cyc();
        wr_cnt = 0;
        reset = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        bit r;
        r = 0;
        for (int k = 0; k < 400 && !r; k++) begin
            @(negedge clk);
            r = in_ready;
        end
        cyc();
        if (!r) check({tag, "_ready_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag);
        bit r;
        r = 0;
        for (int k = 0; k < 3000 && !r; k++) begin
            @(negedge clk);
            r = done;
        end
        cyc();
        if (!r) check({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gaps;
        bit r;
        gaps = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        for (int i = 0; i < gaps; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            cyc();
        end
        in_valid = 1'b1;
        in_data  = b;
        r = 0;
        for (int k = 0; k < 50 && !r; k++) begin
            @(negedge clk);
            r = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        if (!r) check("send_byte_timeout", 0, 1);
    endtask

    task automatic send_word(input logic [15:0] w, input int maxgap);
        send_byte(w[15:8], maxgap);
        send_byte(w[7:0], maxgap);
    endtask

    function automatic int image_diff();
        int mm;
        mm = 0;
        for (int a = 0; a < 256; a++)
            if (ram[a] !== 16'(exp_img[a])) mm++;
        return mm;
    endfunction

    initial begin
        int base;
        int nz;

        // Reset release, idle input: 256 zero writes then ready.
        do_reset();
        wait_ready("clear0");
        check("clear_write_count", wr_cnt, 256);
        nz = 0;
        for (int a = 0; a < 256; a++) if (ram[a] !== 16'h0000) nz++;
        check("clear_nonzero_words", nz, 0);
        @(negedge clk);
        check("post_clear_in_ready", int'(in_ready), 1);
        check("post_clear_cpu_reset", int'(cpu_reset), 1);
        cyc();

        // Collatz program, gap-free.
        base = wr_cnt;
        send_byte(8'h14, 0);
        for (int k = 0; k < 20; k++) send_word(prog_a[k], 0);
        wait_done("collatz");
        for (int k = 0; k < 20; k++) check($sformatf("collatz_word%0d", k), int'(ram[k]), int'(prog_a[k]));
        check("collatz_done", int'(done), 1);
        check("collatz_cpu_reset", int'(cpu_reset), 0);
        check("collatz_writes", wr_cnt - base, 20);
        check("collatz_image", image_diff(), 0);
        for (int a = 0; a < 256; a++) image_a[a] = ram[a];

        // Bytes offered in DONE are not consumed.
        base = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom); cyc();
        end
        in_valid = 1'b0;
        check("done_no_consume_writes", wr_cnt - base, 0);
        check("done_still_done", int'(done), 1);

        // Start in DONE: next cycle shows reset held and the first clear write.
        pulse_start();
        @(negedge clk);
        check("start_cpu_reset", int'(cpu_reset), 1);
        check("start_done", int'(done), 0);
        check("start_mem_we", int'(mem_we), 1);
        check("start_mem_addr", int'(mem_addr), 0);
        cyc();

        // Same program with random valid gaps.
        wait_ready("gap");
        base = wr_cnt;
        send_byte(8'h14, 5);
        for (int k = 0; k < 20; k++) send_word(prog_a[k], 5);
        wait_done("gap");
        nz = 0;
        for (int a = 0; a < 256; a++) if (ram[a] !== image_a[a]) nz++;
        check("gap_image_vs_gapfree", nz, 0);
        check("gap_writes", wr_cnt - base, 20);

        // N=0 means 256 words; word k = k.
        pulse_start();
        wait_ready("full");
        base = wr_cnt;
        a0_cnt = 0;
        send_byte(8'h00, 0);
        for (int k = 0; k < 256; k++) send_word(16'(k), 0);
        wait_done("full");
        repeat (10) cyc();
        check("full_word255", int'(ram[255]), 16'h00FF);
        check("full_word0", int'(ram[0]), 0);
        check("full_addr0_writes", a0_cnt, 1);
        check("full_writes", wr_cnt - base, 256);
        check("full_done", int'(done), 1);
        check("full_image", image_diff(), 0);

        // Start during LO is ignored.
        pulse_start();
        wait_ready("lo");
        base = wr_cnt;
        send_byte(8'h03, 0);
        send_word(16'hA1B2, 0);
        send_byte(8'hC3, 0);
        pulse_start();
        @(negedge clk);
        check("lo_start_done", int'(done), 0);
        check("lo_start_ready", int'(in_ready), 1);
        cyc();
        send_byte(8'hD4, 0);
        send_word(16'hE5F6, 0);
        wait_done("lo");
        check("lo_word1", int'(ram[1]), 16'hC3D4);
        check("lo_writes", wr_cnt - base, 3);

        // Reset after 3 of 5 words (mid-word), then a fresh program.
        pulse_start();
        wait_ready("abort");
        send_byte(8'h05, 2);
        for (int k = 0; k < 3; k++) send_word(16'($urandom), 2);
        send_byte(8'h77, 0);
        do_reset();
        wait_ready("abort_clear");
        check("abort_clear_writes", wr_cnt, 256);
        for (int k = 0; k < 5; k++) prog_b[k] = 16'($urandom);
        send_byte(8'h05, 3);
        for (int k = 0; k < 5; k++) send_word(prog_b[k], 3);
        wait_done("abort");
        check("abort_word4", int'(ram[4]), int'(prog_b[4]));
        check("abort_word5", int'(ram[5]), 0);
        check("abort_image", image_diff(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
